// File: rtl/avl_tx_mailbox.sv
// rtl/avl_tx_mailbox.sv - register-bus mailbox: host pushes words into a FIFO that drains to the TX stream
module avl_tx_mailbox #(
   parameter int pADDR_WIDTH = 8,
   parameter int pDATA_WIDTH = 32,
   parameter int pDEPTH      = 16
) (
   input  logic                   avl_clock,
   input  logic                   avl_rst_n,
   input  logic [pADDR_WIDTH-1:0] s_avl_addr,
   input  logic                   s_avl_wrena,
   input  logic [pDATA_WIDTH-1:0] s_avl_wrdata,
   input  logic                   s_avl_rdena,
   output logic [pDATA_WIDTH-1:0] s_avl_rddata,
   output logic                   s_avl_irq,
   output logic                   s_avl_wrq,
   output logic [pDATA_WIDTH-1:0] tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready
);

   localparam int PW = $clog2(pDEPTH);
   localparam int LW = PW + 1;

   localparam logic [pADDR_WIDTH-1:0] A_DATA   = pADDR_WIDTH'(0);
   localparam logic [pADDR_WIDTH-1:0] A_STATUS = pADDR_WIDTH'(1);
   localparam logic [pADDR_WIDTH-1:0] A_IRQ_EN = pADDR_WIDTH'(2);
   localparam logic [pADDR_WIDTH-1:0] A_THRESH = pADDR_WIDTH'(3);
   localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'(4);

   logic [pDATA_WIDTH-1:0] mem [pDEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [LW-1:0]          level;
   logic [LW-1:0]          thresh;
   logic [1:0]             irq_en;
   logic                   ovf;

   logic                   empty;
   logic                   full;
   logic                   data_wr;
   logic                   push;
   logic                   drop;
   logic                   pop;
   logic                   flush;
   logic                   ovf_clr;
   logic [pDATA_WIDTH-1:0] rd_word;

   // Full/empty come from the registered level, so a same-cycle pop never rescues a push to a full FIFO.
   assign empty   = (level == '0);
   assign full    = (level == LW'(pDEPTH));
   assign data_wr = s_avl_wrena & (s_avl_addr == A_DATA);
   assign push    = data_wr & ~full;
   assign drop    = data_wr & full;
   assign pop     = ~empty & tx_ready;
   assign flush   = s_avl_wrena & (s_avl_addr == A_CTRL) & s_avl_wrdata[0];
   assign ovf_clr = s_avl_wrena & (s_avl_addr == A_STATUS) & s_avl_wrdata[18];

   assign tx_valid  = ~empty;
   assign tx_data   = tx_valid ? mem[rd_ptr] : '0;
   assign s_avl_wrq = full;

   always_ff @(posedge avl_clock) begin
      if (push) begin
         mem[wr_ptr] <= s_avl_wrdata;
      end
   end

   always_comb begin
      rd_word = '0;
      case (s_avl_addr)
         A_STATUS: begin
            rd_word[LW-1:0] = level;
            rd_word[16]     = empty;
            rd_word[17]     = full;
            rd_word[18]     = ovf;
         end
         A_IRQ_EN: rd_word[1:0]    = irq_en;
         A_THRESH: rd_word[LW-1:0] = thresh;
         default:  rd_word         = '0;
      endcase
   end

   always_ff @(posedge avl_clock or negedge avl_rst_n) begin
      if (!avl_rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         ovf          <= 1'b0;
         irq_en       <= '0;
         thresh       <= '0;
         s_avl_rddata <= '0;
         s_avl_irq    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(push) - LW'(pop);
         end
         // A drop in the same cycle as a clear leaves the overflow flag set.
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
         if (s_avl_wrena && (s_avl_addr == A_IRQ_EN)) irq_en <= s_avl_wrdata[1:0];
         if (s_avl_wrena && (s_avl_addr == A_THRESH)) thresh <= s_avl_wrdata[LW-1:0];
         if (s_avl_rdena) s_avl_rddata <= rd_word;
         s_avl_irq <= (irq_en[0] & (level <= thresh)) | (irq_en[1] & ovf);
      end
   end

endmodule

// File: tb/tb_avl_tx_mailbox.sv
// tb/tb_avl_tx_mailbox.sv - directed bench for avl_tx_mailbox with scoreboard queue
module tb_avl_tx_mailbox;

   logic        clk;
   logic        rst_n;
   logic [7:0]  s_avl_addr;
   logic        s_avl_wrena;
   logic [31:0] s_avl_wrdata;
   logic        s_avl_rdena;
   logic [31:0] s_avl_rddata;
   logic        s_avl_irq;
   logic        s_avl_wrq;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb[$];
   logic [1:0]  m_en     = '0;
   logic [4:0]  m_thresh = '0;
   logic        m_ovf    = 1'b0;
   logic        m_irq    = 1'b0;
   logic [31:0] m_rd     = '0;

   avl_tx_mailbox dut (
      .avl_clock    (clk),
      .avl_rst_n    (rst_n),
      .s_avl_addr   (s_avl_addr),
      .s_avl_wrena  (s_avl_wrena),
      .s_avl_wrdata (s_avl_wrdata),
      .s_avl_rdena  (s_avl_rdena),
      .s_avl_rddata (s_avl_rddata),
      .s_avl_irq    (s_avl_irq),
      .s_avl_wrq    (s_avl_wrq),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [7:0] a, input int sz);
      logic [31:0] r;
      r = '0;
      case (a)
         8'd1: begin
            r[4:0] = sz[4:0];
            r[16]  = (sz == 0);
            r[17]  = (sz == 16);
            r[18]  = m_ovf;
         end
         8'd2: r[1:0] = m_en;
         8'd3: r[4:0] = m_thresh;
         default: r = '0;
      endcase
      return r;
   endfunction

   // One bus cycle: check outputs against the model, predict next state, clock, check registered outputs.
   task automatic cycle();
      int   sz;
      logic data_wr;
      logic irq_n;
      logic flush;
      sz      = sb.size();
      data_wr = s_avl_wrena && (s_avl_addr == 8'd0);
      flush   = s_avl_wrena && (s_avl_addr == 8'd4) && s_avl_wrdata[0];
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, sz != 0});
      chk("wrq", {31'd0, s_avl_wrq}, {31'd0, sz == 16});
      if (sz != 0) chk("tx_data", tx_data, sb[0]);
      irq_n = (m_en[0] && (sz <= int'(m_thresh))) || (m_en[1] && m_ovf);
      if (s_avl_rdena) m_rd = rd_model(s_avl_addr, sz);
      if (flush) begin
         sb.delete();
      end else begin
         if (tx_ready && sz != 0) void'(sb.pop_front());
         if (data_wr && sz < 16) sb.push_back(s_avl_wrdata);
      end
      if (data_wr && sz == 16) m_ovf = 1'b1;
      else if (s_avl_wrena && s_avl_addr == 8'd1 && s_avl_wrdata[18]) m_ovf = 1'b0;
      if (s_avl_wrena && s_avl_addr == 8'd2) m_en = s_avl_wrdata[1:0];
      if (s_avl_wrena && s_avl_addr == 8'd3) m_thresh = s_avl_wrdata[4:0];
      @(posedge clk);
      @(negedge clk);
      s_avl_wrena = 1'b0;
      s_avl_rdena = 1'b0;
      m_irq = irq_n;
      chk("rddata", s_avl_rddata, m_rd);
      chk("irq", {31'd0, s_avl_irq}, {31'd0, m_irq});
   endtask

   task automatic push(input logic [31:0] d);
      s_avl_addr   = 8'd0;
      s_avl_wrdata = d;
      s_avl_wrena  = 1'b1;
      cycle();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      s_avl_addr   = a;
      s_avl_wrdata = d;
      s_avl_wrena  = 1'b1;
      cycle();
   endtask

   task automatic rd(input logic [7:0] a);
      s_avl_addr  = a;
      s_avl_rdena = 1'b1;
      cycle();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rddata"}, s_avl_rddata, 32'd0);
      chk({tag, "_irq"}, {31'd0, s_avl_irq}, 32'd0);
      chk({tag, "_wrq"}, {31'd0, s_avl_wrq}, 32'd0);
      chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      chk({tag, "_tx_data"}, tx_data, 32'd0);
   endtask

   initial begin
      clk          = 1'b0;
      rst_n        = 1'b0;
      s_avl_addr   = '0;
      s_avl_wrena  = 1'b0;
      s_avl_wrdata = '0;
      s_avl_rdena  = 1'b0;
      tx_ready     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;

      // basic push, no drain
      push(32'hA5A5_0001);
      push(32'hA5A5_0002);
      push(32'hA5A5_0003);
      rd(8'd1);
      chk("t1_status", s_avl_rddata, 32'h0000_0003);
      chk("t1_valid", {31'd0, tx_valid}, 32'd1);
      chk("t1_data", tx_data, 32'hA5A5_0001);

      // fill, overflow drop, clear ovf
      for (int i = 3; i < 16; i++) push(32'h1000_0000 + i);
      chk("t2_wrq", {31'd0, s_avl_wrq}, 32'd1);
      push(32'hDEAD_BEEF);
      rd(8'd1);
      chk("t2_status_ovf", s_avl_rddata, 32'h0006_0010);
      wr(8'd1, 32'h0004_0000);
      rd(8'd1);
      chk("t2_status_clr", s_avl_rddata, 32'h0002_0010);

      // drain to 5, then simultaneous push/pop with pointer wrap
      tx_ready = 1'b1;
      repeat (11) cycle();
      for (int i = 0; i < 40; i++) push(32'hC0DE_0000 + i);
      tx_ready = 1'b0;
      rd(8'd1);
      chk("t3_status", s_avl_rddata, 32'h0000_0005);

      // low-water interrupt
      wr(8'd3, 32'hFFFF_FFE2);
      wr(8'd2, 32'hFFFF_FFFD);
      rd(8'd3);
      chk("t4_thresh", s_avl_rddata, 32'h0000_0002);
      rd(8'd2);
      chk("t4_irq_en", s_avl_rddata, 32'h0000_0001);
      tx_ready = 1'b1;
      cycle();
      tx_ready = 1'b0;
      cycle();
      cycle();
      chk("t4_irq_lvl4", {31'd0, s_avl_irq}, 32'd0);
      tx_ready = 1'b1;
      cycle();
      cycle();
      tx_ready = 1'b0;
      cycle();
      chk("t4_irq_lvl2", {31'd0, s_avl_irq}, 32'd1);
      push(32'h4444_0001);
      cycle();
      chk("t4_irq_lvl3", {31'd0, s_avl_irq}, 32'd0);

      // undecoded addresses
      rd(8'h81);
      chk("bad_addr_rd", s_avl_rddata, 32'd0);
      wr(8'h80, 32'h1234_5678);
      rd(8'd1);
      chk("bad_addr_wr", s_avl_rddata, 32'h0000_0003);

      // flush at level 7 with same-cycle pop
      for (int i = 0; i < 4; i++) push(32'h5555_0000 + i);
      rd(8'd1);
      chk("t5_level7", s_avl_rddata, 32'h0000_0007);
      tx_ready = 1'b1;
      wr(8'd4, 32'h0000_0001);
      tx_ready = 1'b0;
      chk("t5_valid", {31'd0, tx_valid}, 32'd0);
      rd(8'd1);
      chk("t5_status", s_avl_rddata, 32'h0001_0000);

      // overflow interrupt, ovf survives flush
      wr(8'd2, 32'h0000_0002);
      for (int i = 0; i < 17; i++) push(32'h6666_0000 + i);
      cycle();
      chk("ovf_irq", {31'd0, s_avl_irq}, 32'd1);
      wr(8'd4, 32'h0000_0001);
      rd(8'd1);
      chk("ovf_kept", s_avl_rddata, 32'h0005_0000);

      // asynchronous reset mid-drain
      wr(8'd1, 32'h0004_0000);
      for (int i = 0; i < 6; i++) push(32'h7777_0000 + i);
      tx_ready = 1'b1;
      cycle();
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("arst");
      sb.delete();
      m_en     = '0;
      m_thresh = '0;
      m_ovf    = 1'b0;
      m_irq    = 1'b0;
      m_rd     = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      tx_ready = 1'b0;
      rd(8'd1);
      chk("arst_status", s_avl_rddata, 32'h0001_0000);
      rd(8'd2);
      chk("arst_irq_en", s_avl_rddata, 32'd0);
      rd(8'd3);
      chk("arst_thresh", s_avl_rddata, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
